ara_compl_sync: RTL and testbench
=================================

# ara_compl_sync

Completion synchronizer for the multi-cluster Ara system. It sits between the `pe_compl_o` outputs of all `ara_macro` instances and their `pe_compl_i` inputs. It counts per-cluster, per-VFU completion pulses and broadcasts a single synchronized completion pulse to every cluster once all clusters have completed the same instruction on that VFU. This keeps vector instruction retirement in lockstep across clusters.

## Interface

Parameters:
- `NrClusters`, default 4: number of Ara instances; legal range is 1 to 16.
- `NrVFUs`, default `ara_pkg::NrVFUs`: number of completion channels per cluster.
- `CntWidth`, default 2: width of each outstanding-completion counter; maximum count is 2^CntWidth-1.

Ports:
- Clock and reset: clock `clk_i`; reset `rst_ni`, asynchronous, active-low.
- `pe_compl_i`, input, `NrClusters` x `NrVFUs`: one-cycle completion pulse per cluster per VFU; several bits may be set in the same cycle.
- `pe_compl_o`, output, `NrClusters` x `NrVFUs`: synchronized completion pulse; within a VFU column, all cluster rows are always identical.
- `pending_o`, output, `NrVFUs`: bit v is high while any cluster has a nonzero counter on VFU v.
- `overflow_o`, output, 1: sticky error flag, set when a counter saturates.

## Operation

- One counter `cnt[c][v]` per (cluster c, VFU v), `CntWidth` bits wide, reset to 0.
- **Release condition:** `rel[v]` = AND over all c of (`cnt[c][v] != 0` OR `pe_compl_i[c][v]`).
  - An incoming pulse counts toward its own release, so the last-arriving cluster does not wait an extra cycle.
- **Counter update**, per (c, v):
  - Pulse and no release: increment.
  - Release and no pulse: decrement.
  - Both pulse and release: hold.
  - Neither: hold.
  - A release never underflows a counter, because of the release condition.
- **Saturation:** a pulse arriving when `cnt == max` with no release leaves the count at max, drops the pulse, and sets `overflow_o`.
  - `overflow_o` stays set until reset.
- **Output:** `pe_compl_o[c][v]` is registered and equals `rel[v]` from the previous cycle, for every c.
- **VFU independence:** VFU channels are fully independent. Releases on different VFUs may occur in the same cycle.
- **Queued completions:** a cluster that completes twice on VFU v before the others complete once holds a count of 2. It then produces two releases, on separate cycles, once the other clusters catch up.
- **Pending status:** `pending_o[v]` = OR over all c of (`cnt[c][v] != 0`), taken combinationally from the registered counters.
- **Single cluster (`NrClusters == 1`):** every input pulse appears on the output exactly one cycle later and the counters stay 0.
- There is no backpressure. Downstream clusters must accept a completion pulse in every cycle.

## Timing

- Latency from the last-arriving input pulse to the output pulse is exactly 1 cycle.
- Output pulse width is 1 cycle per release. Back-to-back releases on the same VFU produce pulses on consecutive cycles.
- Reset values: all counters 0, `pe_compl_o` = 0, `pending_o` = 0, `overflow_o` = 0.
- Reset asserted mid-operation discards all outstanding counts. No output pulse is produced for them after reset is released.
- No combinational path exists from `pe_compl_i` to `pe_compl_o`.
- `pending_o` is combinational from registers only.

## Test plan

- **Simultaneous completion:** NrClusters=4; assert `pe_compl_i[*][2]` in cycle 0.
  - Expect `pe_compl_o[*][2]` = 1 in cycle 1 only.
  - Expect `pending_o` = 0 throughout.
- **Staggered completion:** clusters 0, 1, 2, 3 pulse VFU 0 in cycles 0, 3, 5, 9.
  - Expect `pending_o[0]` = 1 in cycles 1 through 9.
  - Expect the output pulse in cycle 10, and all counters 0 afterward.
- **Queued completions:** cluster 0 pulses VFU 1 in cycles 0 and 1; clusters 1-3 pulse VFU 1 in cycles 4 and 6.
  - Expect output pulses in cycles 5 and 7.
  - Expect `cnt[0][1]` to go 1, 2, 1, 0.
- **Saturation:** CntWidth=2; cluster 0 pulses VFU 3 four times while the others stay idle.
  - Expect the count to hold at 3 and `overflow_o` = 1 from the cycle after the 4th pulse.
  - Then the others pulse three times: expect exactly three releases.
- **Independent VFUs plus reset:** complete VFUs 0 and 4 fully in the same cycle; expect both output bits set together.
  - Next, partially complete VFU 5 and pulse `rst_ni` low.
  - Expect all outputs and counters 0 afterward, with no spurious release after reset is deasserted.
- **Single cluster:** NrClusters=1; drive a random pulse pattern.
  - Expect output = input delayed by 1 cycle, and `pending_o` never set.

Source files
------------

// File: rtl/ara_compl_sync.sv
// Completion synchronizer: counts per-cluster, per-VFU completion pulses and
// broadcasts one registered completion pulse per VFU once every cluster has completed.
module ara_compl_sync #(
  parameter int unsigned NrClusters = 4,
  // Matches ara_pkg::NrVFUs; kept local so this block stands alone.
  parameter int unsigned NrVFUs     = 7,
  parameter int unsigned CntWidth   = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NrClusters-1:0][NrVFUs-1:0]     pe_compl_i,
  output logic [NrClusters-1:0][NrVFUs-1:0]     pe_compl_o,
  output logic [NrVFUs-1:0]                     pending_o,
  output logic                                  overflow_o
);

  localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  logic [CntWidth-1:0]                 cnt_r   [NrClusters][NrVFUs];
  logic [CntWidth-1:0]                 cnt_d_s [NrClusters][NrVFUs];
  logic [NrClusters-1:0][NrVFUs-1:0]   compl_r;
  logic                                overflow_r;
  logic [NrVFUs-1:0]                   rel_s;
  logic [NrVFUs-1:0]                   pending_s;
  logic                                sat_s;

  // Release decision, pending status and next counter values.
  always_comb begin
    rel_s     = '1;
    pending_s = '0;
    sat_s     = 1'b0;
    cnt_d_s   = cnt_r;
    // A pulse arriving this cycle counts toward its own release.
    for (int unsigned v = 0; v < NrVFUs; v++) begin
      for (int unsigned c = 0; c < NrClusters; c++) begin
        if ((cnt_r[c][v] == '0) && !pe_compl_i[c][v]) begin
          rel_s[v] = 1'b0;
        end else begin
          rel_s[v] = rel_s[v];
        end
        pending_s[v] = pending_s[v] | (cnt_r[c][v] != '0);
      end
    end
    for (int unsigned c = 0; c < NrClusters; c++) begin
      for (int unsigned v = 0; v < NrVFUs; v++) begin
        case ({pe_compl_i[c][v], rel_s[v]})
          2'b10: begin
            // A saturated counter drops the pulse and flags the loss.
            if (cnt_r[c][v] == CntMax) begin
              sat_s         = 1'b1;
              cnt_d_s[c][v] = cnt_r[c][v];
            end else begin
              cnt_d_s[c][v] = cnt_r[c][v] + CntOne;
            end
          end
          2'b01:   cnt_d_s[c][v] = cnt_r[c][v] - CntOne;
          default: cnt_d_s[c][v] = cnt_r[c][v];
        endcase
      end
    end
  end

  // Counter, broadcast pulse and sticky overflow registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r      <= '{default: '0};
      compl_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      cnt_r      <= cnt_d_s;
      compl_r    <= {NrClusters{rel_s}};
      overflow_r <= overflow_r | sat_s;
    end
  end

  assign pe_compl_o = compl_r;
  assign pending_o  = pending_s;
  assign overflow_o = overflow_r;

endmodule

// File: tb/tb_ara_compl_sync.sv
// Self-checking bench for ara_compl_sync: directed scenarios with fixed expectations
// plus randomized traffic against a saturating-count reference model.
module tb_ara_compl_sync;
  localparam int NC = 4;
  localparam int NV = 7;
  localparam int CMAX = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [NC-1:0][NV-1:0] pi4, po4;
  logic [NV-1:0]         pend4;
  logic                  ovf4;
  logic [0:0][NV-1:0]    pi1, po1;
  logic [NV-1:0]         pend1;
  logic                  ovf1;

  int mcnt [NC][NV];
  logic [NC-1:0][NV-1:0] exp_o4;
  logic [NV-1:0]         exp_pend4;
  logic                  exp_ovf4;
  logic [NV-1:0]         exp_o1;
  int checks = 0;
  int errors = 0;

  ara_compl_sync #(.NrClusters(NC), .NrVFUs(NV), .CntWidth(2)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .pe_compl_i(pi4),
    .pe_compl_o(po4), .pending_o(pend4), .overflow_o(ovf4));

  ara_compl_sync #(.NrClusters(1), .NrVFUs(NV), .CntWidth(2)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .pe_compl_i(pi1),
    .pe_compl_o(po1), .pending_o(pend1), .overflow_o(ovf1));

  always #5 clk = ~clk;

  function automatic logic [NC-1:0][NV-1:0] rep(input logic [NV-1:0] v);
    logic [NC-1:0][NV-1:0] r;
    for (int c = 0; c < NC; c++) r[c] = v;
    return r;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NC; c++)
      for (int v = 0; v < NV; v++) mcnt[c][v] = 0;
    exp_o4 = '0; exp_pend4 = '0; exp_ovf4 = 1'b0; exp_o1 = '0;
  endtask

  // One clock: apply pulses, advance the model, leave outputs settled for checking.
  task automatic step(input logic [NC-1:0][NV-1:0] p4, input logic [NV-1:0] p1);
    logic [NV-1:0] rel;
    int n;
    for (int v = 0; v < NV; v++) begin
      int ready = 0;
      for (int c = 0; c < NC; c++) if (mcnt[c][v] + int'(p4[c][v]) > 0) ready++;
      rel[v] = (ready == NC);
    end
    pi4 = p4; pi1[0] = p1;
    @(posedge clk); #1;
    for (int c = 0; c < NC; c++)
      for (int v = 0; v < NV; v++) begin
        n = mcnt[c][v] + int'(p4[c][v]) - int'(rel[v]);
        if (n > CMAX) begin n = CMAX; exp_ovf4 = 1'b1; end
        mcnt[c][v] = n;
      end
    exp_o4 = rep(rel);
    exp_pend4 = '0;
    for (int c = 0; c < NC; c++)
      for (int v = 0; v < NV; v++) if (mcnt[c][v] != 0) exp_pend4[v] = 1'b1;
    exp_o1 = p1;
    pi4 = '0; pi1 = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pi4 = '0; pi1 = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (po4 !== '0 || pend4 !== '0 || ovf4 !== 1'b0 || po1 !== '0 || pend1 !== '0 || ovf1 !== 1'b0) begin
      errors++;
      $display("FAIL reset: o4=%h pend4=%h ovf4=%b o1=%h pend1=%h ovf1=%b, want all 0",
               po4, pend4, ovf4, po1, pend1, ovf1);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_simultaneous();
    logic [NC-1:0][NV-1:0] want;
    for (int i = 0; i < 3; i++) begin
      step((i == 0) ? rep(7'h04) : '0, '0);
      want = (i == 0) ? rep(7'h04) : '0;
      checks++;
      if (po4 !== want || pend4 !== 7'h00) begin
        errors++;
        $display("FAIL simultaneous cyc%0d: o=%h pend=%h, want o=%h pend=00", i + 1, po4, pend4, want);
      end
    end
  endtask

  task automatic test_staggered();
    logic [NC-1:0][NV-1:0] p, want;
    for (int i = 0; i < 12; i++) begin
      p = '0;
      case (i)
        0: p[0][0] = 1'b1;
        3: p[1][0] = 1'b1;
        5: p[2][0] = 1'b1;
        9: p[3][0] = 1'b1;
        default: p = '0;
      endcase
      step(p, '0);
      want = (i == 9) ? rep(7'h01) : '0;
      checks++;
      if (po4 !== want || pend4 !== ((i <= 8) ? 7'h01 : 7'h00)) begin
        errors++;
        $display("FAIL staggered cyc%0d: o=%h pend=%h, want o=%h pend=%h",
                 i + 1, po4, pend4, want, (i <= 8) ? 7'h01 : 7'h00);
      end
    end
  endtask

  task automatic test_queued();
    logic [NC-1:0][NV-1:0] p, want;
    for (int i = 0; i < 9; i++) begin
      p = '0;
      if (i == 0 || i == 1) p[0][1] = 1'b1;
      if (i == 4 || i == 6) begin p[1][1] = 1'b1; p[2][1] = 1'b1; p[3][1] = 1'b1; end
      step(p, '0);
      want = (i == 4 || i == 6) ? rep(7'h02) : '0;
      checks++;
      if (po4 !== want || pend4 !== ((i <= 5) ? 7'h02 : 7'h00)) begin
        errors++;
        $display("FAIL queued cyc%0d: o=%h pend=%h, want o=%h pend=%h",
                 i + 1, po4, pend4, want, (i <= 5) ? 7'h02 : 7'h00);
      end
    end
  endtask

  task automatic test_saturation();
    logic [NC-1:0][NV-1:0] p;
    int releases = 0;
    for (int i = 0; i < 9; i++) begin
      p = '0;
      if (i <= 3) p[0][3] = 1'b1;
      if (i >= 4 && i <= 6) begin p[1][3] = 1'b1; p[2][3] = 1'b1; p[3][3] = 1'b1; end
      step(p, '0);
      if (po4[0][3]) releases++;
      checks++;
      if (ovf4 !== (i >= 3) || pend4 !== ((i <= 5) ? 7'h08 : 7'h00) || po4 !== exp_o4) begin
        errors++;
        $display("FAIL saturation cyc%0d: ovf=%b pend=%h o=%h, want ovf=%b pend=%h o=%h",
                 i + 1, ovf4, pend4, po4, (i >= 3), (i <= 5) ? 7'h08 : 7'h00, exp_o4);
      end
    end
    checks++;
    if (releases != 3) begin
      errors++;
      $display("FAIL saturation_releases: got %0d, want 3", releases);
    end
  endtask

  task automatic test_independent_reset();
    logic [NC-1:0][NV-1:0] p;
    step(rep(7'h11), '0);
    checks++;
    if (po4 !== rep(7'h11)) begin
      errors++;
      $display("FAIL independent: o=%h, want %h", po4, rep(7'h11));
    end
    p = '0; p[0][5] = 1'b1; p[1][5] = 1'b1;
    step(p, '0);
    checks++;
    if (pend4 !== 7'h20 || po4 !== '0) begin
      errors++;
      $display("FAIL partial: pend=%h o=%h, want pend=20 o=0", pend4, po4);
    end
    #2 rst_n = 1'b0;
    #2;
    model_clear();
    checks++;
    if (po4 !== '0 || pend4 !== '0 || ovf4 !== 1'b0) begin
      errors++;
      $display("FAIL midreset: o=%h pend=%h ovf=%b, want all 0", po4, pend4, ovf4);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step('0, '0);
      checks++;
      if (po4 !== '0 || pend4 !== '0 || ovf4 !== 1'b0) begin
        errors++;
        $display("FAIL postreset cyc%0d: o=%h pend=%h ovf=%b, want all 0", i, po4, pend4, ovf4);
      end
    end
  endtask

  task automatic test_single_cluster();
    logic [NV-1:0] p1;
    for (int i = 0; i < 60; i++) begin
      p1 = NV'($urandom);
      step('0, p1);
      checks++;
      if (po1[0] !== p1 || pend1 !== '0 || ovf1 !== 1'b0) begin
        errors++;
        $display("FAIL single cyc%0d: o=%h pend=%h ovf=%b, want o=%h pend=0 ovf=0",
                 i, po1[0], pend1, ovf1, p1);
      end
    end
  endtask

  task automatic test_random();
    logic [NC-1:0][NV-1:0] p;
    for (int i = 0; i < 300; i++) begin
      for (int c = 0; c < NC; c++)
        for (int v = 0; v < NV; v++) p[c][v] = ($urandom_range(0, 99) < 30);
      step(p, '0);
      checks++;
      if (po4 !== exp_o4 || pend4 !== exp_pend4 || ovf4 !== exp_ovf4) begin
        errors++;
        $display("FAIL random cyc%0d: o=%h pend=%h ovf=%b, want o=%h pend=%h ovf=%b",
                 i, po4, pend4, ovf4, exp_o4, exp_pend4, exp_ovf4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_staggered();
    test_queued();
    test_saturation();
    test_independent_reset();
    test_single_cluster();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
